// File: rtl/cache_arb_pkg.sv
// ============================================================================
//  Module   : cache_arb_pkg
//  Brief    : Shared types for the two-requester cache port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_arb_pkg;

    localparam int CA_ADDR_W = 5;
    localparam int CA_DATA_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic                 wren;
        logic [CA_ADDR_W-1:0] addr;
        logic [CA_DATA_W-1:0] data;
    } cmd_t;

    typedef struct packed {
        logic [CA_DATA_W-1:0] data;
        logic                 hit;
        logic                 err;
    } rsp_t;

endpackage

`default_nettype wire

// File: rtl/arb_timeout_counter.sv
// ============================================================================
//  Module   : arb_timeout_counter
//  Brief    : Counts cycles spent waiting; flags the LIMIT-th waiting cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_timeout_counter #(
    parameter int LIMIT = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             W       = $clog2(LIMIT + 1);
    localparam logic [W-1:0]   LIMIT_V = LIMIT[W-1:0];

    logic [W-1:0] count;
    logic [W-1:0] count_next;

    assign count_next = count + 1'b1;
    // Fires during the cycle whose increment brings the count up to LIMIT.
    assign expired    = enable && (count_next == LIMIT_V);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_port_arbiter.sv
// ============================================================================
//  Module   : cache_port_arbiter
//  Brief    : Round-robin front end serialising two requesters onto one cache port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W  = CA_ADDR_W,
    parameter int DATA_W  = CA_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic              req0_wren,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_hit,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic              req1_wren,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_hit,
    output logic              rsp1_err,
    output logic              c_valid,
    output logic              c_wren,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_data,
    input  logic              c_ready,
    input  logic              c_rsp_valid,
    input  logic [DATA_W-1:0] c_rsp_data,
    input  logic              c_rsp_hit,
    output logic              busy,
    output logic              grant_id
);

    state_t state;
    logic   rr_ptr;
    cmd_t   cmd;
    rsp_t   rsp0_q;
    rsp_t   rsp1_q;
    rsp_t   rsp_in;
    logic   any_valid;
    logic   winner;
    logic   can_grant;
    logic   finish;
    logic   expired;

    assign any_valid = req0_valid | req1_valid;
    assign winner    = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    // Ready is combinational, so it is masked while reset is held.
    assign can_grant = reset_n && (state == ST_IDLE) && any_valid;

    assign req0_ready = can_grant && !winner;
    assign req1_ready = can_grant &&  winner;

    // A response only counts once the cache has taken the command.
    assign finish = ((state == ST_ISSUE) && c_ready && c_rsp_valid) ||
                    ((state == ST_WAIT)  && (c_rsp_valid || expired));

    // A real response always beats a coincident watchdog expiry.
    assign rsp_in = c_rsp_valid ? '{data: c_rsp_data, hit: c_rsp_hit, err: 1'b0}
                                : '{data: '0,         hit: 1'b0,      err: 1'b1};

    arb_timeout_counter #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (state == ST_ISSUE),
        .enable (state == ST_WAIT),
        .expired(expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= 1'b0;
            grant_id   <= 1'b0;
            cmd        <= '0;
            c_valid    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_q     <= '0;
            rsp1_q     <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;

            if (finish) begin
                if (grant_id) begin
                    rsp1_q     <= rsp_in;
                    rsp1_valid <= 1'b1;
                end else begin
                    rsp0_q     <= rsp_in;
                    rsp0_valid <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        cmd      <= winner ? '{wren: req1_wren, addr: req1_addr, data: req1_data}
                                           : '{wren: req0_wren, addr: req0_addr, data: req0_data};
                        grant_id <= winner;
                        c_valid  <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (c_ready) begin
                        c_valid <= 1'b0;
                        state   <= c_rsp_valid ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (finish) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rr_ptr <= ~grant_id;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign c_wren    = cmd.wren;
    assign c_addr    = cmd.addr;
    assign c_data    = cmd.data;
    assign rsp0_data = rsp0_q.data;
    assign rsp0_hit  = rsp0_q.hit;
    assign rsp0_err  = rsp0_q.err;
    assign rsp1_data = rsp1_q.data;
    assign rsp1_hit  = rsp1_q.hit;
    assign rsp1_err  = rsp1_q.err;
    assign busy      = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
// ============================================================================
//  Module   : tb_cache_port_arbiter
//  Brief    : Transaction-level model plus directed scenarios for the arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_port_arbiter;

    localparam int TO = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0_valid = 1'b0, req0_wren = 1'b0, req0_ready;
    logic [4:0] req0_addr = '0;
    logic [2:0] req0_data = '0;
    logic       rsp0_valid, rsp0_hit, rsp0_err;
    logic [2:0] rsp0_data;
    logic       req1_valid = 1'b0, req1_wren = 1'b0, req1_ready;
    logic [4:0] req1_addr = '0;
    logic [2:0] req1_data = '0;
    logic       rsp1_valid, rsp1_hit, rsp1_err;
    logic [2:0] rsp1_data;
    logic       c_valid, c_wren;
    logic [4:0] c_addr;
    logic [2:0] c_data;
    logic       c_ready = 1'b0, c_rsp_valid = 1'b0, c_rsp_hit = 1'b0;
    logic [2:0] c_rsp_data = '0;
    logic       busy, grant_id;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    cache_port_arbiter #(.ADDR_W(5), .DATA_W(3), .TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_wren(req0_wren), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_hit(rsp0_hit), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_wren(req1_wren), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_hit(rsp1_hit), .rsp1_err(rsp1_err),
        .c_valid(c_valid), .c_wren(c_wren), .c_addr(c_addr), .c_data(c_data),
        .c_ready(c_ready), .c_rsp_valid(c_rsp_valid), .c_rsp_data(c_rsp_data),
        .c_rsp_hit(c_rsp_hit), .busy(busy), .grant_id(grant_id)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Transaction view: who owns the port, whether the cache has taken the
    // command, how many cycles it has been waited on, and a pending pulse.
    bit         m_active, m_acc, m_due, m_owner, m_next, m_grant;
    int         m_waited;
    logic       m_wren;
    logic [4:0] m_addr;
    logic [2:0] m_data;
    logic [2:0] m_ld [2];
    logic       m_lh [2];
    logic       m_le [2];

    int n_rdy0 = 0, n_rdy1 = 0, n_rsp0 = 0, n_rsp1 = 0;
    int acc_cyc = 0, rsp_cyc = 0;
    int q_grant [$];

    task automatic model_finish(input logic [2:0] d, input logic h, input logic e);
        m_ld[m_owner] = d;
        m_lh[m_owner] = h;
        m_le[m_owner] = e;
        m_active = 1'b0;
        m_due    = 1'b1;
    endtask

    always @(negedge clock) begin : compare
        bit any, win, idle;
        if (!reset_n) begin
            m_active = 0; m_acc = 0; m_due = 0; m_owner = 0; m_next = 0; m_grant = 0;
            m_waited = 0;
            for (int k = 0; k < 2; k++) begin
                m_ld[k] = '0; m_lh[k] = 1'b0; m_le[k] = 1'b0;
            end
            check("reset_outputs",
                  {req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp0_hit, rsp0_err,
                   rsp1_valid, rsp1_data, rsp1_hit, rsp1_err, c_valid, c_wren, c_addr,
                   c_data, busy, grant_id}, 32'd0);
        end else begin
            any  = req0_valid | req1_valid;
            win  = (req0_valid && req1_valid) ? m_next : req1_valid;
            idle = !m_active && !m_due;
            check("req0_ready", req0_ready, idle && any && !win);
            check("req1_ready", req1_ready, idle && any && win);
            check("c_valid", c_valid, m_active && !m_acc);
            if (m_active && !m_acc)
                check("c_cmd", {c_wren, c_addr, c_data}, {m_wren, m_addr, m_data});
            check("rsp0", {rsp0_valid, rsp0_data, rsp0_hit, rsp0_err},
                  {m_due && !m_owner, m_ld[0], m_lh[0], m_le[0]});
            check("rsp1", {rsp1_valid, rsp1_data, rsp1_hit, rsp1_err},
                  {m_due && m_owner, m_ld[1], m_lh[1], m_le[1]});
            check("busy", busy, m_active || m_due);
            check("grant_id", grant_id, m_grant);

            if (req0_ready) begin n_rdy0++; q_grant.push_back(0); acc_cyc = cyc; end
            if (req1_ready) begin n_rdy1++; q_grant.push_back(1); acc_cyc = cyc; end
            if (rsp0_valid) begin n_rsp0++; rsp_cyc = cyc; end
            if (rsp1_valid) begin n_rsp1++; rsp_cyc = cyc; end

            if (m_due) begin
                m_due  = 1'b0;
                m_next = !m_owner;
            end else if (!m_active) begin
                if (any) begin
                    m_active = 1'b1; m_acc = 1'b0; m_owner = win; m_grant = win;
                    {m_wren, m_addr, m_data} = win ? {req1_wren, req1_addr, req1_data}
                                                   : {req0_wren, req0_addr, req0_data};
                end
            end else if (!m_acc) begin
                if (c_ready) begin
                    m_acc = 1'b1; m_waited = 0;
                    if (c_rsp_valid) model_finish(c_rsp_data, c_rsp_hit, 1'b0);
                end
            end else begin
                m_waited++;
                if (c_rsp_valid) model_finish(c_rsp_data, c_rsp_hit, 1'b0);
                else if (m_waited == TO) model_finish(3'b000, 1'b0, 1'b1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int b0, b1, bs, br;
        bit seen;
        int pc;

        // Reset state.
        repeat (2) tick();
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single read from requester 0.
        b0 = n_rsp0; b1 = n_rsp1;
        req0_valid = 1'b1; req0_wren = 1'b0; req0_addr = 5'b00100; req0_data = 3'b000;
        @(negedge clock);
        check("rd_ready0", req0_ready, 1);
        tick(); req0_valid = 1'b0; c_ready = 1'b1;
        tick(); c_ready = 1'b0;
        tick(); c_rsp_valid = 1'b1; c_rsp_data = 3'b011; c_rsp_hit = 1'b1;
        tick(); c_rsp_valid = 1'b0; c_rsp_data = 3'b000; c_rsp_hit = 1'b0;
        @(negedge clock);
        check("rd_rsp0", {rsp0_valid, rsp0_data, rsp0_hit, rsp0_err}, {1'b1, 3'b011, 1'b1, 1'b0});
        tick(); tick();
        check("rd_pulses0", n_rsp0 - b0, 1);
        check("rd_pulses1", n_rsp1 - b1, 0);
        check("rd_latency", rsp_cyc - acc_cyc, 4);

        // Write from requester 1 with the cache stalling; requester 0 waits.
        req0_valid = 1'b1; req0_wren = 1'b0; req0_addr = 5'b01010; req0_data = 3'b111;
        req1_valid = 1'b1; req1_wren = 1'b1; req1_addr = 5'b11011; req1_data = 3'b101;
        @(negedge clock);
        check("wr_ready1", req1_ready, 1);
        check("wr_ready0_acc", req0_ready, 0);
        tick(); req1_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                c_ready = 1'b1; c_rsp_valid = 1'b1; c_rsp_data = 3'b101; c_rsp_hit = 1'b0;
                req0_valid = 1'b0;
            end
            @(negedge clock);
            check("wr_c_cmd", {c_valid, c_wren, c_addr, c_data}, {1'b1, 1'b1, 5'b11011, 3'b101});
            check("wr_ready0", req0_ready, 0);
            tick();
        end
        c_ready = 1'b0; c_rsp_valid = 1'b0; c_rsp_data = 3'b000;
        @(negedge clock);
        check("wr_rsp1", {rsp1_valid, rsp1_data, rsp1_hit, rsp1_err, rsp0_valid},
              {1'b1, 3'b101, 1'b0, 1'b0, 1'b0});
        tick(); tick();

        // Watchdog abort: cache takes the command and never answers.
        req0_valid = 1'b1; req0_wren = 1'b0; req0_addr = 5'b00001;
        @(negedge clock);
        tick(); req0_valid = 1'b0; c_ready = 1'b1;
        tick(); c_ready = 1'b0;
        seen = 1'b0; pc = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (rsp0_valid) begin
                seen = 1'b1; pc = cyc;
                check("tmo_rsp0", {rsp0_data, rsp0_hit, rsp0_err}, {3'b000, 1'b0, 1'b1});
            end
        end
        check("tmo_seen", seen, 1);
        check("tmo_latency", pc - acc_cyc, 5);
        tick();
        bs = n_rsp0 + n_rsp1;
        c_rsp_valid = 1'b1; c_rsp_data = 3'b111; c_rsp_hit = 1'b1;
        repeat (3) tick();
        c_rsp_valid = 1'b0; c_rsp_data = 3'b000; c_rsp_hit = 1'b0;
        tick();
        check("late_no_pulse", n_rsp0 + n_rsp1 - bs, 0);
        check("late_hold", {rsp0_data, rsp0_hit, rsp0_err}, {3'b000, 1'b0, 1'b1});

        // Cache accepts and answers in the same cycle.
        req1_valid = 1'b1; req1_wren = 1'b0; req1_addr = 5'b10010;
        @(negedge clock);
        check("comb_ready1", req1_ready, 1);
        tick(); req1_valid = 1'b0; c_ready = 1'b1; c_rsp_valid = 1'b1; c_rsp_data = 3'b110; c_rsp_hit = 1'b1;
        @(negedge clock);
        check("comb_c_valid", c_valid, 1);
        tick(); c_ready = 1'b0; c_rsp_valid = 1'b0; c_rsp_data = 3'b000; c_rsp_hit = 1'b0;
        @(negedge clock);
        check("comb_rsp1", {rsp1_valid, rsp1_data, rsp1_hit, rsp1_err}, {1'b1, 3'b110, 1'b1, 1'b0});
        tick();
        check("comb_latency", rsp_cyc - acc_cyc, 2);
        tick();

        // Reset in the middle of WAIT, then contention right after release.
        req0_valid = 1'b1; req0_wren = 1'b0; req0_addr = 5'b00111;
        @(negedge clock);
        tick(); req0_valid = 1'b0; c_ready = 1'b1;
        tick(); c_ready = 1'b0;
        @(negedge clock);
        check("mid_wait_busy", busy, 1);
        tick();
        bs = n_rsp0 + n_rsp1;
        reset_n = 1'b0;
        @(negedge clock);
        check("rst_mid", {busy, rsp0_valid, rsp1_valid, rsp0_data, rsp0_hit, rsp0_err,
                          rsp1_data, rsp1_hit, rsp1_err}, 32'd0);
        tick(); tick();
        check("rst_no_pulse", n_rsp0 + n_rsp1 - bs, 0);
        q_grant.delete();
        b0 = n_rdy0; b1 = n_rdy1;
        req0_valid = 1'b1; req0_wren = 1'b1; req0_addr = 5'b00011; req0_data = 3'b001;
        req1_valid = 1'b1; req1_wren = 1'b0; req1_addr = 5'b11100; req1_data = 3'b010;
        c_ready = 1'b1; c_rsp_valid = 1'b1; c_rsp_data = 3'b010; c_rsp_hit = 1'b1;
        reset_n = 1'b1;
        br = 0;
        for (int i = 0; i < 60 && br < 6; i++) begin
            tick();
            br = n_rdy0 + n_rdy1 - b0 - b1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) tick();
        c_ready = 1'b0; c_rsp_valid = 1'b0;
        check("cont_count", q_grant.size(), 6);
        for (int i = 0; i < 6; i++)
            check("cont_grant", (i < q_grant.size()) ? q_grant[i] : 99, i % 2);
        check("cont_ready0", n_rdy0 - b0, 3);
        check("cont_ready1", n_rdy1 - b1, 3);
        check("cont_last_grant", grant_id, 1);
        check("cont_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
